fsm_seq_monitor: RTL and testbench

Passive checker that consumes the 2-bit state code driven by the three-state ring FSM (S0→S1→S2→S0, S3 unused) and verifies the sequence cycle by cycle. It sits on the FSM's `out` bus as the receiving end of that interface. It locks onto the sequence, flags illegal codes, skipped states and stalls, and reports sticky fault status plus error and loop counts. It is used both as an in-design safety monitor and as a bench-side scoreboard for FSM bug-injection experiments.

---
 rtl/fsm_seq_monitor_pkg.sv | 36 +++
 rtl/fsm_seq_monitor_sat_counter.sv | 20 ++
 rtl/fsm_seq_monitor.sv | 148 ++++++++++++++
 tb/tb_fsm_seq_monitor.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fsm_seq_monitor_pkg.sv
// Shared types for the ring-FSM sequence monitor: observed state codes,
// monitor FSM states, error codes and the ring successor function.
package fsm_mon_pkg;

    // Same encoding as the monitored three-state ring FSM; S3 is never legal.
    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state;

    typedef enum logic [1:0] {
        M_UNSYNC = 2'b00,
        M_LOCKED = 2'b01,
        M_FAULT  = 2'b10
    } mon_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_ILLEGAL = 2'b01,
        ERR_SKIP    = 2'b10,
        ERR_STALL   = 2'b11
    } err_code_e;

    // Ring successor S0->S1->S2->S0; S3 has no successor and maps to S0.
    function automatic state next_state(input state s);
        case (s)
            S0:      next_state = S1;
            S1:      next_state = S2;
            S2:      next_state = S0;
            default: next_state = S0;
        endcase
    endfunction

endpackage

// File: rtl/fsm_seq_monitor_sat_counter.sv
// Saturating up-counter: increments on inc, holds at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count up on inc until the all-ones ceiling is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/fsm_seq_monitor.sv
// Passive checker for the S0->S1->S2->S0 ring FSM state bus: locks onto the
// sequence, flags illegal codes, skipped states and stalls, and keeps sticky
// fault status plus error and loop counts. All outputs are registered.
module fsm_seq_monitor
    import fsm_mon_pkg::*;
#(
    parameter int STALL_MAX = 4,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sample,
    input  logic [1:0]       state_in,
    input  logic             clr,
    output logic             locked,
    output logic             fault,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] loop_cnt
);

    localparam int SW = $clog2(STALL_MAX + 1);
    localparam logic [SW-1:0] STALL_LIM = SW'(STALL_MAX);

    mon_state_e       mon_q, mon_d;
    state             prev_q, prev_d;
    logic [SW-1:0]    stall_q, stall_d;
    logic [SW-1:0]    stall_inc;
    logic             err_q, err_d;
    err_code_e        code_q, code_d;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] loop_q, loop_d;
    logic             raise;
    err_code_e        raise_code;
    state             obs;

    assign obs       = state'(state_in);
    assign stall_inc = stall_q + SW'(1);

    // Monitor FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mon_q <= M_UNSYNC;
        end else begin
            mon_q <= mon_d;
        end
    end

    // Next-state, sequence check and error decision for the captured sample.
    always_comb begin
        mon_d      = mon_q;
        prev_d     = prev_q;
        stall_d    = stall_q;
        err_d      = 1'b0;
        code_d     = code_q;
        fault_d    = fault_q;
        loop_d     = loop_q;
        raise      = 1'b0;
        raise_code = ERR_NONE;

        if (clr) begin
            // Clear wins over a coincident sample, which is dropped.
            mon_d   = M_UNSYNC;
            fault_d = 1'b0;
            code_d  = ERR_NONE;
            stall_d = '0;
        end else if (sample) begin
            case (mon_q)
                M_UNSYNC: begin
                    if (obs == S0) begin
                        mon_d   = M_LOCKED;
                        prev_d  = S0;
                        stall_d = '0;
                    end else if (obs == S3) begin
                        raise      = 1'b1;
                        raise_code = ERR_ILLEGAL;
                    end
                end
                M_LOCKED: begin
                    // prev is never S3, so these branches cannot overlap.
                    if (obs == S3) begin
                        raise      = 1'b1;
                        raise_code = ERR_ILLEGAL;
                    end else if (obs == prev_q) begin
                        stall_d = stall_inc;
                        if (stall_inc == STALL_LIM) begin
                            raise      = 1'b1;
                            raise_code = ERR_STALL;
                        end
                    end else if (obs == next_state(prev_q)) begin
                        prev_d  = obs;
                        stall_d = '0;
                        if (prev_q == S2) begin
                            loop_d = loop_q + CNT_W'(1);
                        end
                    end else begin
                        raise      = 1'b1;
                        raise_code = ERR_SKIP;
                    end
                end
                default: ;
            endcase

            if (raise) begin
                err_d   = 1'b1;
                code_d  = raise_code;
                fault_d = 1'b1;
                mon_d   = M_FAULT;
            end
        end
    end

    // Tracking registers and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= S0;
            stall_q <= '0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            fault_q <= 1'b0;
            loop_q  <= '0;
        end else begin
            prev_q  <= prev_d;
            stall_q <= stall_d;
            err_q   <= err_d;
            code_q  <= code_d;
            fault_q <= fault_d;
            loop_q  <= loop_d;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_err_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (raise),
        .cnt  (err_cnt)
    );

    assign locked   = (mon_q == M_LOCKED);
    assign fault    = fault_q;
    assign err      = err_q;
    assign err_code = code_q;
    assign loop_cnt = loop_q;

endmodule

// File: tb/tb_fsm_seq_monitor.sv
// Directed bench for fsm_seq_monitor (STALL_MAX=4, CNT_W=2): a vector table
// for the basic sequence/error cases plus hand sequences for stall, clear
// priority, counter saturation/wrap and asynchronous reset.
module tb_fsm_seq_monitor;

    logic       clk;
    logic       rst_n;
    logic       sample;
    logic [1:0] state_in;
    logic       clr;
    logic       locked;
    logic       fault;
    logic       err;
    logic [1:0] err_code;
    logic [1:0] err_cnt;
    logic [1:0] loop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       smp;
        logic [1:0] st;
        logic       c;
        logic       lk;
        logic       flt;
        logic       er;
        logic [1:0] code;
        logic [1:0] ec;
        logic [1:0] lc;
    } vec_t;

    vec_t tbl[$];

    fsm_seq_monitor #(
        .STALL_MAX(4),
        .CNT_W    (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sample  (sample),
        .state_in(state_in),
        .clr     (clr),
        .locked  (locked),
        .fault   (fault),
        .err     (err),
        .err_code(err_code),
        .err_cnt (err_cnt),
        .loop_cnt(loop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int lk, input int flt, input int er,
                           input int code, input int ec, input int lc);
        chk({tag, ".locked"},   int'(locked),   lk);
        chk({tag, ".fault"},    int'(fault),    flt);
        chk({tag, ".err"},      int'(err),      er);
        chk({tag, ".err_code"}, int'(err_code), code);
        chk({tag, ".err_cnt"},  int'(err_cnt),  ec);
        chk({tag, ".loop_cnt"}, int'(loop_cnt), lc);
    endtask

    // Present inputs, let one rising edge capture them, then settle before checks.
    task automatic drive(input logic smp, input logic [1:0] st, input logic c);
        sample   = smp;
        state_in = st;
        clr      = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        sample   = 1'b0;
        state_in = 2'd0;
        clr      = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic smp, input logic [1:0] st, input logic c,
                                input logic lk, input logic flt, input logic er,
                                input logic [1:0] code, input logic [1:0] ec,
                                input logic [1:0] lc);
        vec_t v;
        v.smp = smp; v.st = st; v.c = c;
        v.lk = lk; v.flt = flt; v.er = er; v.code = code; v.ec = ec; v.lc = lc;
        return v;
    endfunction

    initial begin
        //             smp st clr  lk flt er code ec lc
        tbl.push_back(mk(1, 0, 0,   1, 0, 0, 0, 0, 0));  // lock on S0
        tbl.push_back(mk(1, 1, 0,   1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2, 0,   1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0,   1, 0, 0, 0, 0, 1));  // first loop
        tbl.push_back(mk(1, 1, 0,   1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 2, 0,   1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0,   1, 0, 0, 0, 0, 2));  // second loop
        tbl.push_back(mk(0, 3, 0,   1, 0, 0, 0, 0, 2));  // unsampled S3 ignored
        tbl.push_back(mk(1, 1, 0,   1, 0, 0, 0, 0, 2));  // locked at S1
        tbl.push_back(mk(1, 3, 0,   0, 1, 1, 1, 1, 2));  // ILLEGAL
        tbl.push_back(mk(1, 0, 0,   0, 1, 0, 1, 1, 2));  // no relock in fault
        tbl.push_back(mk(0, 0, 1,   0, 0, 0, 0, 1, 2));  // clr
        tbl.push_back(mk(1, 0, 0,   1, 0, 0, 0, 1, 2));  // relock
        tbl.push_back(mk(1, 2, 0,   0, 1, 1, 2, 2, 2));  // SKIP S0->S2
        tbl.push_back(mk(0, 0, 1,   0, 0, 0, 0, 2, 2));
        tbl.push_back(mk(1, 1, 0,   0, 0, 0, 0, 2, 2));  // S1 ignored unsynced
        tbl.push_back(mk(1, 2, 0,   0, 0, 0, 0, 2, 2));  // S2 ignored unsynced
        tbl.push_back(mk(1, 3, 0,   0, 1, 1, 1, 3, 2));  // ILLEGAL while unsynced
        tbl.push_back(mk(0, 0, 1,   0, 0, 0, 0, 3, 2));
        tbl.push_back(mk(1, 0, 0,   1, 0, 0, 0, 3, 2));
        tbl.push_back(mk(1, 1, 0,   1, 0, 0, 0, 3, 2));
        tbl.push_back(mk(1, 0, 0,   0, 1, 1, 2, 3, 2));  // SKIP S1->S0, cnt saturated
        tbl.push_back(mk(1, 2, 0,   0, 1, 0, 2, 3, 2));  // fault ignores samples

        // Reset state
        rst_n    = 1'b0;
        sample   = 1'b0;
        state_in = 2'd0;
        clr      = 1'b0;
        #2;
        chk_all("reset_async", 0, 0, 0, 0, 0, 0);
        do_reset();
        chk_all("reset", 0, 0, 0, 0, 0, 0);

        // Table-driven vectors
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].smp, tbl[i].st, tbl[i].c);
            chk_all($sformatf("vec%0d", i), int'(tbl[i].lk), int'(tbl[i].flt), int'(tbl[i].er),
                    int'(tbl[i].code), int'(tbl[i].ec), int'(tbl[i].lc));
        end

        // Stall with idle gaps: 4 S0 samples fine, 5th raises STALL
        do_reset();
        drive(1, 0, 0);
        chk_all("stall_lock", 1, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            drive(0, 0, 0);
            chk_all($sformatf("stall_gap%0d", i), 1, 0, 0, 0, 0, 0);
            drive(1, 0, 0);
            if (i < 4) chk_all($sformatf("stall_s%0d", i + 1), 1, 0, 0, 0, 0, 0);
            else       chk_all("stall_err", 0, 1, 1, 3, 1, 0);
        end
        drive(0, 0, 0);
        chk_all("stall_hold", 0, 1, 0, 3, 1, 0);

        // clr beats a coincident S0 sample; next S0 relocks
        drive(1, 0, 1);
        chk_all("clr_prio", 0, 0, 0, 0, 1, 0);
        drive(1, 0, 0);
        chk_all("clr_relock", 1, 0, 0, 0, 1, 0);
        // stall count cleared by relock: three more S0 stay clean
        drive(1, 0, 0);
        drive(1, 0, 0);
        drive(1, 0, 0);
        chk_all("relock_stall3", 1, 0, 0, 0, 1, 0);

        // err_cnt saturation over four faults, loop_cnt wrap, async reset
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 1);
            drive(1, 3, 0);
            chk_all($sformatf("sat%0d", k), 0, 1, 1, 1, (k + 1 > 3) ? 3 : k + 1, 0);
        end
        drive(0, 0, 1);
        drive(1, 0, 0);
        chk_all("sat_lock", 1, 0, 0, 0, 3, 0);
        for (int k = 0; k < 4; k++) begin
            drive(1, 1, 0);
            drive(1, 2, 0);
            drive(1, 0, 0);
            chk_all($sformatf("wrap%0d", k), 1, 0, 0, 0, 3, (k + 1) % 4);
        end
        drive(1, 1, 0);
        drive(1, 2, 0);
        chk_all("pre_rst", 1, 0, 0, 0, 3, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(0, 0, 0);
        chk_all("post_rst", 0, 0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
